jtframe_mr_ddrmux: RTL and testbench

Two-requester arbiter and sequencer for the MiSTer DDRAM port. It sits between the core-side DDR clients, e.g. a frame-buffer writer and a ROM/sample reader, and the single DDRAM Avalon-style interface. It grants the port to one requester at a time and runs the complete read or write burst on that requester's behalf. It returns read beats and write-beat acknowledges to that requester, then signals completion.

---
 rtl/jtframe_mr_ddrmux.sv | 179 +++++++++++++++++
 tb/tb_jtframe_mr_ddrmux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_mr_ddrmux.sv
// Two-port arbiter/sequencer for the DDRAM port; command 1 clk after grant, done 1 clk after last beat.
// Backpressure: ddram_busy stalls command/write beats; din_ok marks each accepted write beat.
module jtframe_mr_ddrmux #(
    parameter logic RR = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_rd,
    input  logic        p1_rd,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [28:0] p0_addr,
    input  logic [28:0] p1_addr,
    input  logic [7:0]  p0_burstcnt,
    input  logic [7:0]  p1_burstcnt,
    input  logic [63:0] p0_din,
    input  logic [63:0] p1_din,
    input  logic [7:0]  p0_be,
    input  logic [7:0]  p1_be,
    output logic        p0_din_ok,
    output logic        p1_din_ok,
    output logic        p0_dout_ok,
    output logic        p1_dout_ok,
    output logic        p0_done,
    output logic        p1_done,
    output logic [63:0] dout,
    output logic        ddram_clk,
    input  logic        ddram_busy,
    output logic [7:0]  ddram_burstcnt,
    output logic [28:0] ddram_addr,
    input  logic [63:0] ddram_dout,
    input  logic        ddram_dout_ready,
    output logic        ddram_rd,
    output logic [63:0] ddram_din,
    output logic [7:0]  ddram_be,
    output logic        ddram_we
);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

    state_t      state, state_nxt;
    logic        gnt, gnt_nxt;
    logic        last, last_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic [7:0]  limit, limit_nxt;
    logic        rd_nxt, we_nxt;
    logic [28:0] addr_nxt;
    logic [7:0]  bc_nxt;
    logic        done0_nxt, done1_nxt;

    logic        req0, req1, sel, sel_we;
    logic [28:0] sel_addr;
    logic [7:0]  sel_bc;
    logic        beat, accept, last_beat, fin;

    assign ddram_clk = clk;
    assign dout      = ddram_dout;
    assign ddram_din = gnt ? p1_din : p0_din;
    assign ddram_be  = gnt ? p1_be  : p0_be;

    // A read beat may already arrive in the cycle the command is taken
    assign beat      = ddram_dout_ready &&
                       (state == RD_DATA || (state == RD_CMD && !ddram_busy));
    assign accept    = (state == WR) && ddram_we && !ddram_busy;
    assign last_beat = (cnt == limit - 8'd1);

    assign p0_dout_ok = beat   & ~gnt;
    assign p1_dout_ok = beat   &  gnt;
    assign p0_din_ok  = accept & ~gnt;
    assign p1_din_ok  = accept &  gnt;

    always_comb begin
        req0 = p0_rd | p0_we;
        req1 = p1_rd | p1_we;
        if (req0 && req1)
            sel = RR ? ~last : 1'b0;
        else
            sel = req1;
        sel_we   = sel ? p1_we   : p0_we;
        sel_addr = sel ? p1_addr : p0_addr;
        sel_bc   = sel ? p1_burstcnt : p0_burstcnt;
        if (sel_bc == 8'd0)
            sel_bc = 8'd1;
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = cnt;
        limit_nxt = limit;
        rd_nxt    = ddram_rd;
        we_nxt    = ddram_we;
        addr_nxt  = ddram_addr;
        bc_nxt    = ddram_burstcnt;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_nxt   = sel;
                    last_nxt  = sel;
                    cnt_nxt   = 8'd0;
                    limit_nxt = sel_bc;
                    addr_nxt  = sel_addr;
                    bc_nxt    = sel_bc;
                    if (sel_we) begin
                        we_nxt    = 1'b1;
                        state_nxt = WR;
                    end else begin
                        rd_nxt    = 1'b1;
                        state_nxt = RD_CMD;
                    end
                end
            end
            RD_CMD: begin
                if (!ddram_busy) begin
                    rd_nxt    = 1'b0;
                    state_nxt = RD_DATA;
                    if (beat) begin
                        cnt_nxt = cnt + 8'd1;
                        fin     = last_beat;
                    end
                end
            end
            RD_DATA: begin
                if (beat) begin
                    cnt_nxt = cnt + 8'd1;
                    fin     = last_beat;
                end
            end
            WR: begin
                if (accept) begin
                    cnt_nxt = cnt + 8'd1;
                    if (last_beat) begin
                        we_nxt = 1'b0;
                        fin    = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (fin) begin
            done0_nxt = ~gnt;
            done1_nxt = gnt;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gnt            <= 1'b0;
            last           <= 1'b1;
            cnt            <= 8'd0;
            limit          <= 8'd0;
            ddram_rd       <= 1'b0;
            ddram_we       <= 1'b0;
            ddram_addr     <= 29'd0;
            ddram_burstcnt <= 8'd0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
        end else begin
            state          <= state_nxt;
            gnt            <= gnt_nxt;
            last           <= last_nxt;
            cnt            <= cnt_nxt;
            limit          <= limit_nxt;
            ddram_rd       <= rd_nxt;
            ddram_we       <= we_nxt;
            ddram_addr     <= addr_nxt;
            ddram_burstcnt <= bc_nxt;
            p0_done        <= done0_nxt;
            p1_done        <= done1_nxt;
        end
    end

endmodule

// File: tb/tb_jtframe_mr_ddrmux.sv
// Scoreboard bench for jtframe_mr_ddrmux: read/write bursts, backpressure, arbitration, reset.
`timescale 1ns/1ps
module tb_jtframe_mr_ddrmux;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_rd, p1_rd, p0_we, p1_we;
    logic [28:0] p0_addr, p1_addr;
    logic [7:0]  p0_burstcnt, p1_burstcnt;
    logic [63:0] p0_din, p1_din;
    logic [7:0]  p0_be, p1_be;
    logic        p0_din_ok, p1_din_ok, p0_dout_ok, p1_dout_ok, p0_done, p1_done;
    logic [63:0] dout;
    logic        ddram_clk, ddram_busy, ddram_dout_ready, ddram_rd, ddram_we;
    logic [7:0]  ddram_burstcnt, ddram_be;
    logic [28:0] ddram_addr;
    logic [63:0] ddram_dout, ddram_din;

    // fixed-priority instance with constant stimulus
    logic        f_p0_din_ok, f_p1_din_ok, f_p0_dout_ok, f_p1_dout_ok, f_p0_done, f_p1_done;
    logic [63:0] f_dout, f_din;
    logic        f_clk, f_rd, f_we;
    logic [7:0]  f_bc, f_be;
    logic [28:0] f_addr;

    int nchecks = 0;
    int nerrors = 0;
    int f_n0 = 0;
    int f_n1 = 0;
    logic mdl_last;

    logic [64:0] rd_q[$];
    logic [64:0] wr_q[$];
    logic        done_q[$];

    always #5 clk = ~clk;

    jtframe_mr_ddrmux #(.RR(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .p0_rd(p0_rd), .p1_rd(p1_rd), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_burstcnt(p0_burstcnt), .p1_burstcnt(p1_burstcnt),
        .p0_din(p0_din), .p1_din(p1_din), .p0_be(p0_be), .p1_be(p1_be),
        .p0_din_ok(p0_din_ok), .p1_din_ok(p1_din_ok),
        .p0_dout_ok(p0_dout_ok), .p1_dout_ok(p1_dout_ok),
        .p0_done(p0_done), .p1_done(p1_done), .dout(dout),
        .ddram_clk(ddram_clk), .ddram_busy(ddram_busy),
        .ddram_burstcnt(ddram_burstcnt), .ddram_addr(ddram_addr),
        .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
        .ddram_rd(ddram_rd), .ddram_din(ddram_din), .ddram_be(ddram_be),
        .ddram_we(ddram_we)
    );

    jtframe_mr_ddrmux #(.RR(1'b0)) u_fix (
        .clk(clk), .rst(rst),
        .p0_rd(1'b1), .p1_rd(1'b0), .p0_we(1'b0), .p1_we(1'b1),
        .p0_addr(29'h10), .p1_addr(29'h20),
        .p0_burstcnt(8'd1), .p1_burstcnt(8'd1),
        .p0_din(64'd0), .p1_din(64'd0), .p0_be(8'hFF), .p1_be(8'hFF),
        .p0_din_ok(f_p0_din_ok), .p1_din_ok(f_p1_din_ok),
        .p0_dout_ok(f_p0_dout_ok), .p1_dout_ok(f_p1_dout_ok),
        .p0_done(f_p0_done), .p1_done(f_p1_done), .dout(f_dout),
        .ddram_clk(f_clk), .ddram_busy(1'b0),
        .ddram_burstcnt(f_bc), .ddram_addr(f_addr),
        .ddram_dout(64'h0), .ddram_dout_ready(1'b1),
        .ddram_rd(f_rd), .ddram_din(f_din), .ddram_be(f_be),
        .ddram_we(f_we)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wdat(input logic p, input int k);
        return {31'h0, p, 32'hC0DE_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] rdat(input logic p, input int k);
        return {32'h1234_0000 + 32'(k), 31'h0, p};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every DUT output event pops and compares against the bench's expectation
    always @(negedge clk) begin : monitor
        logic [64:0] e;
        if (p0_dout_ok || p1_dout_ok) begin
            if (rd_q.size() == 0)
                check("dout_ok_unexpected", {62'd0, p1_dout_ok, p0_dout_ok}, 64'd0);
            else begin
                e = rd_q.pop_front();
                check("rd_port", {63'd0, p1_dout_ok}, {63'd0, e[64]});
                check("rd_data", dout, e[63:0]);
            end
        end
        if (p0_din_ok || p1_din_ok) begin
            if (wr_q.size() == 0)
                check("din_ok_unexpected", {62'd0, p1_din_ok, p0_din_ok}, 64'd0);
            else begin
                e = wr_q.pop_front();
                check("wr_port", {63'd0, p1_din_ok}, {63'd0, e[64]});
                check("wr_data", ddram_din, e[63:0]);
                check("wr_be", {56'd0, ddram_be}, {56'd0, e[64] ? p1_be : p0_be});
            end
        end
        if (p0_done || p1_done) begin
            if (done_q.size() == 0)
                check("done_unexpected", {62'd0, p1_done, p0_done}, 64'd0);
            else
                check("done_port", {63'd0, p1_done}, {63'd0, done_q.pop_front()});
        end
        if (!rst) begin
            if (f_p0_done) f_n0++;
            if (f_p1_done || f_p1_din_ok || f_p1_dout_ok || f_we) f_n1++;
        end
    end

    task automatic do_read(input logic p, input logic [28:0] a, input logic [7:0] bc, input int nbusy);
        int lim;
        lim = (bc == 8'd0) ? 1 : int'(bc);
        if (p) begin p1_rd = 1'b1; p1_addr = a; p1_burstcnt = bc; end
        else   begin p0_rd = 1'b1; p0_addr = a; p0_burstcnt = bc; end
        tick;
        mdl_last = p;
        check("rd_cmd", {63'd0, ddram_rd}, 64'd1);
        check("rd_we_low", {63'd0, ddram_we}, 64'd0);
        check("rd_addr", {35'd0, ddram_addr}, {35'd0, a});
        check("rd_bcnt", {56'd0, ddram_burstcnt}, 64'(lim));
        for (int i = 0; i < nbusy; i++) begin
            ddram_busy = 1'b1;
            tick;
            check("rd_cmd_hold", {63'd0, ddram_rd}, 64'd1);
        end
        ddram_busy = 1'b0;
        tick;
        check("rd_cmd_drop", {63'd0, ddram_rd}, 64'd0);
        for (int k = 0; k < lim; k++) begin
            ddram_dout_ready = 1'b1;
            ddram_dout = rdat(p, k);
            rd_q.push_back({p, rdat(p, k)});
            if (k == lim - 1) done_q.push_back(p);
            tick;
        end
        ddram_dout_ready = 1'b0;
        check("rd_done", {63'd0, p ? p1_done : p0_done}, 64'd1);
        check("rd_addr_stable", {35'd0, ddram_addr}, {35'd0, a});
        if (p) p1_rd = 1'b0; else p0_rd = 1'b0;
        tick;
        check("rd_done_pulse", {63'd0, p ? p1_done : p0_done}, 64'd0);
    endtask

    task automatic do_write(input logic p, input logic [28:0] a, input logic [7:0] bc, input logic [63:0] busy_pat);
        int lim, acc, cyc;
        logic ok;
        lim = (bc == 8'd0) ? 1 : int'(bc);
        for (int k = 0; k < lim; k++) wr_q.push_back({p, wdat(p, k)});
        done_q.push_back(p);
        if (p) begin p1_we = 1'b1; p1_addr = a; p1_burstcnt = bc; p1_din = wdat(p, 0); p1_be = 8'hA5; end
        else   begin p0_we = 1'b1; p0_addr = a; p0_burstcnt = bc; p0_din = wdat(p, 0); p0_be = 8'h3C; end
        tick;
        mdl_last = p;
        check("wr_cmd", {63'd0, ddram_we}, 64'd1);
        check("wr_rd_low", {63'd0, ddram_rd}, 64'd0);
        check("wr_addr", {35'd0, ddram_addr}, {35'd0, a});
        acc = 0;
        cyc = 0;
        while (acc < lim && cyc < 64) begin
            ddram_busy = busy_pat[cyc];
            @(negedge clk);
            ok = p ? p1_din_ok : p0_din_ok;
            tick;
            if (ok) begin
                acc++;
                if (p) p1_din = wdat(p, acc); else p0_din = wdat(p, acc);
            end
            cyc++;
        end
        ddram_busy = 1'b0;
        check("wr_beats", 64'(acc), 64'(lim));
        check("wr_we_drop", {63'd0, ddram_we}, 64'd0);
        check("wr_done", {63'd0, p ? p1_done : p0_done}, 64'd1);
        if (p) p1_we = 1'b0; else p0_we = 1'b0;
        tick;
        check("wr_done_pulse", {63'd0, p ? p1_done : p0_done}, 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int t;
        logic exp_g;
        rst = 1'b1;
        {p0_rd, p1_rd, p0_we, p1_we} = 4'b0;
        p0_addr = '0; p1_addr = '0; p0_burstcnt = '0; p1_burstcnt = '0;
        p0_din = '0; p1_din = '0; p0_be = '0; p1_be = '0;
        ddram_busy = 1'b0; ddram_dout = '0; ddram_dout_ready = 1'b0;
        mdl_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd", {63'd0, ddram_rd}, 64'd0);
        check("rst_we", {63'd0, ddram_we}, 64'd0);
        check("rst_addr", {35'd0, ddram_addr}, 64'd0);
        check("rst_bcnt", {56'd0, ddram_burstcnt}, 64'd0);
        check("rst_done", {62'd0, p1_done, p0_done}, 64'd0);
        check("ddram_clk", {63'd0, ddram_clk}, {63'd0, clk});
        rst = 1'b0;
        tick;

        do_read(1'b0, 29'h100, 8'd4, 0);
        do_write(1'b1, 29'h1ABCDE, 8'd3, 64'b0110);
        do_read(1'b0, 29'h2000, 8'd0, 2);

        // spurious read-data strobes in IDLE and during a write
        ddram_dout_ready = 1'b1;
        ddram_dout = 64'hDEAD_BEEF_DEAD_BEEF;
        repeat (3) tick;
        do_write(1'b0, 29'h40, 8'd2, 64'd0);
        ddram_dout_ready = 1'b0;
        tick;

        // reset in the middle of an 8-beat read
        p0_rd = 1'b1; p0_addr = 29'h300; p0_burstcnt = 8'd8;
        tick;
        tick;
        for (int k = 0; k < 2; k++) begin
            ddram_dout_ready = 1'b1;
            ddram_dout = rdat(1'b0, k);
            rd_q.push_back({1'b0, rdat(1'b0, k)});
            tick;
        end
        ddram_dout = 64'h5555_AAAA_5555_AAAA;
        rst = 1'b1;
        #1;
        check("mid_rst_rd", {63'd0, ddram_rd}, 64'd0);
        check("mid_rst_addr", {35'd0, ddram_addr}, 64'd0);
        check("mid_rst_bcnt", {56'd0, ddram_burstcnt}, 64'd0);
        check("mid_rst_dout_ok", {62'd0, p1_dout_ok, p0_dout_ok}, 64'd0);
        check("mid_rst_done", {62'd0, p1_done, p0_done}, 64'd0);
        mdl_last = 1'b1;
        p0_rd = 1'b0;
        ddram_dout_ready = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        do_read(1'b1, 29'h777, 8'd3, 0);

        // both ports requesting continuously: grants must alternate
        p0_rd = 1'b1; p0_addr = 29'h500; p0_burstcnt = 8'd1;
        p1_we = 1'b1; p1_addr = 29'h600; p1_burstcnt = 8'd1;
        p1_din = 64'hFEED_0000_0000_0001; p1_be = 8'h0F;
        for (int g = 0; g < 4; g++) begin
            t = 0;
            do begin
                tick;
                t++;
            end while (!(ddram_rd || ddram_we) && t < 8);
            check("rr_grant_seen", {63'd0, ddram_rd | ddram_we}, 64'd1);
            exp_g = ~mdl_last;
            check("rr_grant", {63'd0, ddram_we}, {63'd0, exp_g});
            mdl_last = exp_g;
            if (ddram_rd) begin
                tick;
                ddram_dout_ready = 1'b1;
                ddram_dout = rdat(1'b0, 40 + g);
                rd_q.push_back({1'b0, rdat(1'b0, 40 + g)});
                done_q.push_back(1'b0);
                tick;
                ddram_dout_ready = 1'b0;
                check("rr_p0_done", {63'd0, p0_done}, 64'd1);
            end else if (ddram_we) begin
                wr_q.push_back({1'b1, p1_din});
                done_q.push_back(1'b1);
                tick;
                check("rr_p1_done", {63'd0, p1_done}, 64'd1);
            end
        end
        p0_rd = 1'b0;
        p1_we = 1'b0;
        repeat (3) tick;

        check("rd_q_empty", 64'(rd_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        check("fix_p0_served", {63'd0, f_n0 > 10}, 64'd1);
        check("fix_p1_starved", 64'(f_n1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
